// File: rtl/data_sync_src_arbiter_if.sv
// Requester/synchronizer-facing bundle of the source-domain arbiter.
// The requester side (master) drives valid/data; the arbiter side (slave) drives the rest.
interface data_sync_src_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 4
);
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         src_bus_enable;
  logic [BUS_WIDTH-1:0]         Unsync_bus_out;
  logic [GID_W-1:0]             grant_id;
  logic                         busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, src_bus_enable, Unsync_bus_out, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, src_bus_enable, Unsync_bus_out, grant_id, busy
  );
endinterface

// File: rtl/data_sync_src_arbiter.sv
// Round-robin scheduler that issues one word at a time into a bus+enable synchronizer,
// shaping the enable into HOLD high / GAP low so the far side sees one clean rising edge per word.
module data_sync_src_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 3
) (
  input logic                    CLK,
  input logic                    RST,
  data_sync_src_arbiter_if.slave io_arb
);
  localparam int GID_W   = $clog2(NUM_REQ);
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [GID_W-1:0]     r_ptr;
  logic [GID_W-1:0]     r_gid;
  logic                 r_enable;
  logic [BUS_WIDTH-1:0] r_bus;
  logic [GID_W-1:0]     w_win;
  logic                 w_found;
  logic                 w_hs;
  logic [NUM_REQ-1:0]   w_ready;
  logic [BUS_WIDTH-1:0] w_words [NUM_REQ];

  function automatic logic [GID_W-1:0] wrap_add(input logic [GID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return GID_W'(s);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = io_arb.req_data[g*BUS_WIDTH +: BUS_WIDTH];
  end

  // Scan downward from ptr+NUM_REQ-1 so the candidate closest to ptr overwrites the others.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (io_arb.req_valid[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_hs = (r_state == S_IDLE) && w_found && !RST;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_hs)         w_next_state = S_HOLD;
      S_HOLD:  if (r_cnt == '0)  w_next_state = S_GAP;
      S_GAP:   if (r_cnt == '0)  w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = '0;
    if (w_hs) w_ready[w_win] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_enable <= 1'b0;
      r_bus    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_bus    <= w_words[w_win];
            r_gid    <= w_win;
            r_ptr    <= wrap_add(w_win, 1);
            r_enable <= 1'b1;
            r_cnt    <= CNT_W'(HOLD_CYCLES - 1);
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_enable <= 1'b0;
            r_cnt    <= CNT_W'(GAP_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: r_enable <= 1'b0;
      endcase
    end
  end

  assign io_arb.req_ready      = w_ready;
  assign io_arb.src_bus_enable = r_enable;
  assign io_arb.Unsync_bus_out = r_bus;
  assign io_arb.grant_id       = r_gid;
  assign io_arb.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_data_sync_src_arbiter.sv
// Bench for data_sync_src_arbiter: directed scenarios plus random traffic, all checked each
// cycle against a timeline model (cycles since last handshake, rotating-priority winner).
module tb_data_sync_src_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int H = 3;
  localparam int G = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_sync_src_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) arb_if ();

  data_sync_src_arbiter #(
    .NUM_REQ(N), .BUS_WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(G)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .io_arb(arb_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: cycles since last handshake (0 = none in flight), rotating pointer, issued word
  int       since;
  int       m_ptr;
  logic [3:0] m_bus;
  logic [1:0] m_gid;
  int       grants[$];
  int       hs_cyc[$];
  int       cyc;
  int       rises;
  logic     prev_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int winner(input logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    since = 0;
    m_ptr = 0;
    m_bus = '0;
    m_gid = '0;
  endtask

  // One clock: drive at negedge, check #1 later, advance the model for the coming posedge.
  task automatic step(input logic [3:0] v, input logic [15:0] d, input logic r);
    logic exp_busy, exp_en;
    logic [3:0] exp_ready;
    int w;
    @(negedge clk);
    rst = r;
    arb_if.req_valid = v;
    arb_if.req_data  = d;
    #1;
    if (r) model_reset();
    exp_busy  = (since >= 1) && (since <= H + G);
    exp_en    = (since >= 1) && (since <= H);
    w         = (exp_busy || r) ? -1 : winner(v);
    exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
    check("req_ready", 32'(arb_if.req_ready), 32'(exp_ready));
    check("src_bus_enable", 32'(arb_if.src_bus_enable), 32'(exp_en));
    check("busy", 32'(arb_if.busy), 32'(exp_busy));
    check(exp_busy ? "bus_stable" : "bus", 32'(arb_if.Unsync_bus_out), 32'(m_bus));
    check("grant_id", 32'(arb_if.grant_id), 32'(m_gid));
    if (arb_if.src_bus_enable && !prev_en) rises++;
    prev_en = arb_if.src_bus_enable;
    if (w >= 0) begin
      m_bus = 4'(d >> (4 * w));
      m_gid = 2'(w);
      m_ptr = (w + 1) % N;
      since = 1;
      grants.push_back(w);
      hs_cyc.push_back(cyc);
    end else if (since > 0) begin
      since = (since >= H + G) ? 0 : since + 1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 16'h0000, 1'b0);
  endtask

  task automatic clear_log();
    grants.delete();
    hs_cyc.delete();
    rises = 0;
  endtask

  initial begin
    arb_if.req_valid = '0;
    arb_if.req_data  = '0;
    model_reset();
    cyc = 0;
    rises = 0;
    prev_en = 1'b0;

    // 1: reset with random requests, then requester 0 first
    for (int i = 0; i < 3; i++) step(4'($urandom), 16'($urandom), 1'b1);
    step(4'b1111, 16'h4321, 1'b0);
    step(4'b0000, 16'h0000, 1'b0);
    check("t1_first_grant", 32'(arb_if.grant_id), 32'd0);
    check("t1_first_word", 32'(arb_if.Unsync_bus_out), 32'h1);
    idle(7);

    // 2: single requester 2, word A
    step(4'b0100, 16'h0A00, 1'b0);
    check("t2_ready_c0", 32'(arb_if.req_ready), 32'b0100);
    for (int c = 1; c <= 3; c++) begin
      step(4'b0000, 16'h0000, 1'b0);
      check("t2_en_high", 32'(arb_if.src_bus_enable), 32'd1);
      check("t2_bus", 32'(arb_if.Unsync_bus_out), 32'hA);
      check("t2_gid", 32'(arb_if.grant_id), 32'd2);
    end
    for (int c = 4; c <= 6; c++) begin
      step(4'b0100, 16'h0B00, 1'b0);
      check("t2_en_low", 32'(arb_if.src_bus_enable), 32'd0);
      check("t2_ready_gap", 32'(arb_if.req_ready), 32'd0);
    end
    step(4'b0100, 16'h0B00, 1'b0);
    check("t2_ready_c7", 32'(arb_if.req_ready), 32'b0100);
    idle(8);

    // 3: all requesting from ptr=0 -> 0,1,2,3,0, 7 cycles apart
    step(4'b0000, 16'h0000, 1'b1);
    idle(1);
    clear_log();
    for (int i = 0; i < 29; i++) step(4'b1111, 16'(i * 16'h1111 + 16'h0123), 1'b0);
    idle(8);
    check("t3_count", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      check("t3_g0", 32'(grants[0]), 32'd0);
      check("t3_g1", 32'(grants[1]), 32'd1);
      check("t3_g2", 32'(grants[2]), 32'd2);
      check("t3_g3", 32'(grants[3]), 32'd3);
      check("t3_g4", 32'(grants[4]), 32'd0);
      for (int i = 1; i < 5; i++) check("t3_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd7);
    end
    check("t3_rises", 32'(rises), 32'd5);

    // 4: ptr=2 then 1010 held -> 3,1,3,1
    step(4'b0000, 16'h0000, 1'b1);
    idle(1);
    step(4'b0010, 16'h0050, 1'b0);
    clear_log();
    for (int i = 0; i < 28; i++) step(4'b1010, 16'($urandom), 1'b0);
    idle(8);
    check("t4_count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      check("t4_g0", 32'(grants[0]), 32'd3);
      check("t4_g1", 32'(grants[1]), 32'd1);
      check("t4_g2", 32'(grants[2]), 32'd3);
      check("t4_g3", 32'(grants[3]), 32'd1);
    end

    // 5: asynchronous reset in c2 of HOLD
    step(4'b0100, 16'h0700, 1'b0);
    step(4'b0000, 16'h0000, 1'b0);
    step(4'b0000, 16'h0000, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("t5_en_async", 32'(arb_if.src_bus_enable), 32'd0);
    check("t5_busy_async", 32'(arb_if.busy), 32'd0);
    check("t5_bus_async", 32'(arb_if.Unsync_bus_out), 32'd0);
    model_reset();
    rst = 1'b0;
    clear_log();
    step(4'b0011, 16'h0098, 1'b0);
    idle(1);
    check("t5_grant0", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
    check("t5_word", 32'(arb_if.Unsync_bus_out), 32'h8);
    idle(7);

    // 6: requester 1 valid only while busy -> no grant, bus unchanged
    step(4'b0001, 16'h000C, 1'b0);
    clear_log();
    idle(1);
    for (int c = 2; c <= 4; c++) step(4'b0010, 16'h00F0, 1'b0);
    idle(10);
    check("t6_no_grant", 32'(grants.size()), 32'd0);
    check("t6_bus_kept", 32'(arb_if.Unsync_bus_out), 32'hC);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 16'($urandom), ($urandom_range(0, 63) == 0));
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
